// File: rtl/lbp_code_assembler.sv
// Assembles P thresholded interpolation samples into one LBP code with a valid/ready output.
// Optional build macro LBP_ROUND_EN: round the Q8.16 sample to nearest instead of truncating.
module lbp_code_assembler #(
  parameter int unsigned P      = 8,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_first,
  input  logic [7:0]        center_i,
  output logic [P-1:0]      code_o,
  output logic [7:0]        center_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              drop_o
);

  localparam int unsigned CNT_W = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned S_W   = DATA_W - FRAC_W + 1;

  logic [CNT_W-1:0] r_cnt;
  logic [P-2:0]     r_acc;
  logic [7:0]       r_center;
  logic [P-1:0]     r_code;
  logic [7:0]       r_center_out;
  logic             r_valid;
  logic             r_drop;

  logic [S_W-1:0]   w_s;
  logic [7:0]       w_cmp_center;
  logic             w_bit;
  logic             w_accept;
  logic             w_last;
  logic             w_complete;
  logic             w_unused_frac;

  // Integer part of the sample, one bit wider than the centre so 255.5+ rounds to 256.
`ifdef LBP_ROUND_EN
  logic [DATA_W:0] w_sum;
  assign w_sum         = {1'b0, in_data} + (DATA_W+1)'(1 << (FRAC_W - 1));
  assign w_s           = w_sum[DATA_W:FRAC_W];
  assign w_unused_frac = ^w_sum[FRAC_W-1:0];
`else
  assign w_s           = {1'b0, in_data[DATA_W-1:FRAC_W]};
  assign w_unused_frac = ^in_data[FRAC_W-1:0];
`endif

  // A group's first sample compares against the centre arriving with it.
  assign w_cmp_center = in_first ? center_i : r_center;
  assign w_bit        = (w_s >= S_W'(w_cmp_center));

  assign w_last     = (r_cnt == CNT_W'(P - 1));
  assign in_ready   = !rst && !(w_last && r_valid && !ready_i);
  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept && !in_first && w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_center     <= '0;
      r_code       <= '0;
      r_center_out <= '0;
      r_valid      <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      if (w_accept) begin
        if (in_first) begin
          r_center <= center_i;
          r_acc    <= (P-1)'(w_bit);
          r_cnt    <= CNT_W'(1);
          r_drop   <= (r_cnt != '0);
        end else if (r_cnt == '0) begin
          r_drop <= 1'b1;
        end else if (w_last) begin
          r_code       <= {w_bit, r_acc};
          r_center_out <= r_center;
          r_cnt        <= '0;
        end else begin
          r_acc[r_cnt] <= w_bit;
          r_cnt        <= r_cnt + CNT_W'(1);
        end
      end
      // A new code may overwrite the one being consumed in the same cycle.
      if (w_complete) begin
        r_valid <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign code_o   = r_code;
  assign center_o = r_center_out;
  assign valid_o  = r_valid;
  assign drop_o   = r_drop;

endmodule

// File: tb/tb_lbp_code_assembler.sv
// Scoreboard bench for lbp_code_assembler; build with or without LBP_ROUND_EN.
module tb_lbp_code_assembler;
  localparam int unsigned P      = 8;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned FRAC_W = 16;
`ifdef LBP_ROUND_EN
  localparam logic [7:0] BASIC_EXP = 8'hDD;
`else
  localparam logic [7:0] BASIC_EXP = 8'hD5;
`endif

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] ctr;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_first;
  logic [7:0]        center_i;
  logic [P-1:0]      code_o;
  logic [7:0]        center_o;
  logic              valid_o;
  logic              ready_i;
  logic              drop_o;

  lbp_code_assembler #(.P(P), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_first(in_first), .center_i(center_i),
    .code_o(code_o), .center_o(center_o), .valid_o(valid_o),
    .ready_i(ready_i), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_err = 0;
  int   cyc = 0, last_acc = 0, last_hs = 0, prev_hs = 0;
  int   hs_total = 0, n_push = 0, vcnt = 0, dcnt = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] c, input logic [P-1:0][DATA_W-1:0] s);
    logic [7:0] r;
    int v;
    r = '0;
    for (int k = 0; k < P; k++) begin
`ifdef LBP_ROUND_EN
      v = (int'(s[k]) + 32768) / 65536;
`else
      v = int'(s[k]) / 65536;
`endif
      r[k] = (v >= int'(c));
    end
    return r;
  endfunction

  task automatic push(input logic [7:0] code, input logic [7:0] ctr);
    sb.push_back(exp_t'({code, ctr}));
    n_push++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds one beat on the bus until it is accepted; called and returns at posedge+1.
  task automatic beat(input logic [DATA_W-1:0] d, input logic f, input logic [7:0] c);
    logic ok;
    int   guard;
    ok = 1'b0;
    guard = 0;
    in_valid = 1'b1; in_data = d; in_first = f; center_i = c;
    while (!ok && guard < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    chk("beat_accept", ok, 1'b1);
    if (ok) last_acc = cyc;
    in_valid = 1'b0; in_first = 1'b0;
  endtask

  task automatic send_group(input logic [7:0] c, input logic [P-1:0][DATA_W-1:0] s, input int n);
    for (int k = 0; k < n; k++) beat(s[k], k == 0, c);
  endtask

  // Samples within +-2 of the centre with random fractions, to stress the rounding boundary.
  task automatic rand_group(input logic [7:0] c, output logic [P-1:0][DATA_W-1:0] s);
    int b;
    for (int k = 0; k < P; k++) begin
      b = int'(c) + int'($urandom_range(0, 4)) - 2;
      if (b < 0) b = 0;
      if (b > 255) b = 255;
      s[k] = {8'(b), 16'($urandom)};
    end
  endtask

  // Output monitor: pops the scoreboard on every downstream handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (valid_o === 1'b1) vcnt++;
      if (drop_o === 1'b1) dcnt++;
      if (valid_o === 1'b1 && ready_i) begin
        prev_hs = last_hs;
        last_hs = cyc;
        hs_total++;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("code_o", 32'(code_o), 32'(e.code));
          chk("center_o", 32'(center_o), 32'(e.ctr));
        end else begin
          chk("sb_extra_code", hs_total, n_push);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [P-1:0][DATA_W-1:0] g, ga, gb;
    logic [7:0] ca, cb, ea, eb;
    int v0, d0, h0;

    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_data = '0; center_i = '0; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_code", 32'(code_o), 0);
    chk("rst_center", 32'(center_o), 0);
    chk("rst_drop", drop_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Basic group with fractional samples at the rounding boundary.
    g = {24'h647D70, 24'hC80000, 24'h320000, 24'h650000,
         24'h638000, 24'h640000, 24'h5A0000, 24'h780000};
    push(BASIC_EXP, 8'd100);
    v0 = vcnt;
    send_group(8'd100, g, P);
    idle(4);
    chk("basic_valid_cycles", vcnt - v0, 1);
    chk("basic_latency", last_hs, last_acc);

    // Back-to-back groups.
    g = {P{24'h4A0000}};
    push(8'hFF, 8'd74);
    push(8'h00, 8'd119);
    send_group(8'd74, g, P);
    send_group(8'd119, g, P);
    idle(4);
    chk("b2b_gap", last_hs - prev_hs, P);

    // Backpressure: first code held while the second group's last beat stalls.
    ca = 8'd50; cb = 8'd180;
    rand_group(ca, ga);
    rand_group(cb, gb);
    ea = model(ca, ga);
    eb = model(cb, gb);
    push(ea, ca);
    push(eb, cb);
    ready_i = 1'b0;
    send_group(ca, ga, P);
    send_group(cb, gb, P - 1);
    in_valid = 1'b1; in_data = gb[P-1]; in_first = 1'b0; center_i = 8'd0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold_valid", valid_o, 1'b1);
      chk("bp_hold_code", 32'(code_o), 32'(ea));
      chk("bp_hold_center", 32'(center_o), 32'(ca));
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_new_valid", valid_o, 1'b1);
    chk("bp_new_code", 32'(code_o), 32'(eb));
    @(posedge clk); #1;
    idle(3);

    // Resync: in_first after 5 samples drops the partial group.
    rand_group(8'd10, ga);
    g = {24'hD00000, 24'hC70000, 24'h100000, 24'hFF0000,
         24'hC80000, 24'h000000, 24'hC90000, 24'hC80000};
    push(model(8'd200, g), 8'd200);
    d0 = dcnt;
    send_group(8'd10, ga, 5);
    send_group(8'd200, g, P);
    idle(4);
    chk("resync_drop", dcnt - d0, 1);

    // Orphan non-first sample with no group open.
    d0 = dcnt; h0 = hs_total;
    beat(24'h123456, 1'b0, 8'd0);
    idle(3);
    chk("orphan_drop", dcnt - d0, 1);
    chk("orphan_no_code", hs_total - h0, 0);

    // Saturation edge.
    g = {P{24'hFF9999}};
    push(8'hFF, 8'd255);
    send_group(8'd255, g, P);
    idle(3);

    // Mid-group reset.
    rand_group(8'd30, ga);
    d0 = dcnt;
    send_group(8'd30, ga, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("mrst_valid", valid_o, 1'b0);
    chk("mrst_drop", drop_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    rand_group(8'd140, gb);
    push(model(8'd140, gb), 8'd140);
    send_group(8'd140, gb, P);
    idle(4);
    chk("mrst_no_drop", dcnt - d0, 0);

    // Random groups near the centre.
    for (int i = 0; i < 4; i++) begin
      cb = 8'($urandom_range(0, 255));
      rand_group(cb, gb);
      push(model(cb, gb), cb);
      send_group(cb, gb, P);
    end
    idle(5);
    chk("sb_empty", sb.size(), 0);
    chk("code_count", hs_total, n_push);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/lbp_code_assembler.md
# lbp_code_assembler

Consumes the stream of bilinear-interpolated circular samples produced by the interpolation calculator and turns each group of P samples into one local-binary-pattern code. Each sample is thresholded against the neighbourhood's centre pixel and shifted into a P-bit code. The code is presented on a valid/ready output toward the histogram stage. The block sits directly downstream of the interpolation calculator, as the reader of its Q8.16 result word.

## Interface
- P, 8, samples per neighbourhood (one per angle step, 0°..315° at 45°); code width.
- DATA_W, 24, input sample width, unsigned Q8.16.
- FRAC_W, 16, fractional bits of the input sample.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  DATA_W  interpolated sample, unsigned Q8.16.
- in_first  in  1  marks the first sample (angle 0) of a neighbourhood.
- center_i  in  8  centre pixel; sampled only on an accepted beat with in_first=1.
- code_o  out  P  assembled code; bit k = threshold result of sample k.
- center_o  out  8  centre pixel belonging to code_o.
- valid_o  out  1  code_o/center_o valid.
- ready_i  in  1  downstream accepts the code.
- drop_o  out  1  one-cycle pulse: a partial group was discarded.

## Operation
- A beat is accepted when in_valid && in_ready.
- Internal state:
  - sample counter cnt, 0..P-1;
  - accumulating shift register acc[P-1:0];
  - latched centre register;
  - output register (code_o, center_o, valid_o).
- Threshold for each sample:
  - s = integer value of in_data per Configuration, 9 bits wide;
  - bit = (s >= {1'b0, centre}).
  - For an in_first beat, compare against the centre_i value on that same beat, not the latched one.
- Accepted beat with in_first=1:
  - latch centre_i;
  - acc[0] = bit;
  - cnt = 1.
  - If cnt != 0 beforehand, pulse drop_o for one cycle; the partial group is lost.
- Accepted beat with in_first=0 and 0 < cnt < P-1: acc[cnt] = bit; cnt++.
- Accepted beat with in_first=0 and cnt == P-1 (completing):
  - load code_o = {bit, acc[P-2:0]};
  - load center_o = latched centre;
  - set valid_o = 1;
  - cnt = 0.
- Accepted beat with in_first=0 and cnt == 0 (no group open): discard the sample and pulse drop_o.
- in_ready = !rst && !(cnt == P-1 && valid_o && !ready_i).
  - The block stalls only on the completing beat while an unconsumed code is still held.
- Output handshake:
  - valid_o stays high, and code_o/center_o stay stable, until valid_o && ready_i.
  - If a completing beat and a downstream handshake occur in the same cycle, the new code replaces the old one and valid_o stays 1.
  - A downstream handshake with no completing beat clears valid_o.
- Reset in the middle of a group: cnt, acc, the latched centre and the output register all clear. No drop_o pulse is generated by reset.

## Timing
- Reset values:
  - code_o = 0, center_o = 0, valid_o = 0, drop_o = 0;
  - in_ready = 0 while rst is high, 1 in the first cycle after reset.
- Latency: valid_o rises one cycle after the completing beat is accepted.
- Throughput: one sample per cycle. A full code every P cycles with no bubbles when ready_i is held high.
- drop_o is registered and asserts the cycle after the offending beat.
- Throughput is unchanged by the rounding configuration.

## Configuration
- LBP_ROUND_EN defined:
  - s = (in_data + 2^(FRAC_W-1)) >> FRAC_W;
  - the result is 9 bits, so 255.5 and above compares as 256 against the centre.
- LBP_ROUND_EN undefined: s = {1'b0, in_data[DATA_W-1:FRAC_W]} (truncation).

## Test plan
- Reset then basic group:
  - stimulus: centre 100; samples 120, 90, 100, 99.5 (0x638000), 101, 50, 200, 100.49 (0x647D70); in_first on the first sample; ready_i=1.
  - required response: code_o = 0xDD with LBP_ROUND_EN, 0xD5 without; center_o = 100; valid_o high for exactly 1 cycle.
- Back-to-back groups:
  - stimulus: two groups streamed with no gap, centre 74 then 119, all samples 0x4A0000 (74.0).
  - required response: codes 0xFF then 0x00; valid_o pulses exactly P cycles apart.
- Backpressure:
  - stimulus: hold ready_i=0 after the first code; stream a second full group.
  - required response: in_ready drops on the second group's 8th sample; the first code is held stable; releasing ready_i presents the second code the next cycle.
- Resync:
  - stimulus: assert in_first after 5 samples of a group.
  - required response: drop_o pulses once; the next code is built from the new group only.
- Saturation edge:
  - stimulus: centre 255, all samples 0xFF9999 (255.6).
  - required response: code_o = 0xFF in both builds.
- Mid-group reset:
  - stimulus: assert rst for 1 cycle after 3 samples, then send a full group.
  - required response: valid_o = 0 and drop_o = 0 during reset; only the full group produces a code.
